// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
//   Two-requester round-robin arbiter that drives a shared 2:1 data mux and
//   registers the chosen source's beat onto a single output channel.
//
//   Optional feature macro: ARB_HOLD_LIMIT_EN
//     defined   -> a grantee is forced to hand over after MAX_HOLD beats if
//                  the other source is requesting.
//     undefined -> a grant lasts until the grantee drops its request.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   req[1:0]   : req[i]=1 -> source i has a beat this cycle
//   din0, din1 : source data
//   grant[1:0] : one-hot registered grant, 2'b00 when idle
//   sel        : registered mux select (current or last grantee)
//   dout       : registered muxed data
//   dout_valid : dout holds a valid beat
module mux2_rr_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic [1:0]        grant,
  output logic              sel,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  localparam int unsigned CW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          ptr, ptr_nxt;
  logic          sel_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          beat;
  logic          cur;

  // Index of the current grantee; only meaningful in G0/G1.
  assign cur   = (state == G1);
  assign grant = {state == G1, state == G0};

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        if (req == 2'b11) begin
          state_nxt = ptr ? G1 : G0;
          sel_nxt   = ptr;
        end else if (req[0]) begin
          state_nxt = G0;
          sel_nxt   = 1'b0;
        end else if (req[1]) begin
          state_nxt = G1;
          sel_nxt   = 1'b1;
        end
      end
      G0, G1: begin
        if (req[cur]) begin
          beat    = 1'b1;
          cnt_nxt = cnt + 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
          // Tenure limit reached: hand over if the other side waits,
          // otherwise start a fresh tenure for the same grantee.
          if (cnt_nxt == CW'(MAX_HOLD)) begin
            cnt_nxt = '0;
            if (req[~cur]) begin
              state_nxt = cur ? G0 : G1;
              sel_nxt   = ~cur;
              ptr_nxt   = ~cur;
            end
          end
`endif
        end else begin
          ptr_nxt = ~cur;
          cnt_nxt = '0;
          if (req[~cur]) begin
            state_nxt = cur ? G0 : G1;
            sel_nxt   = ~cur;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 1'b0;
      sel   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (beat) begin
      dout       <= cur ? din1 : din0;
      dout_valid <= 1'b1;
    end else begin
      dout_valid <= 1'b0;
    end
  end

endmodule
